// File: rtl/jtag_dtm_pkg.sv
// rtl/jtag_dtm_pkg.sv - shared types and helpers for the JTAG debug transport module
// TAP states, instruction codes, DMI op/state encodings and the DTMCS layout.
package jtag_dtm_pkg;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [4:0] {
    IR_IDCODE = 5'h01,
    IR_DTMCS  = 5'h10,
    IR_DMI    = 5'h11,
    IR_BYPASS = 5'h1f
  } ir_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_IDLE,
    DMI_REQ,
    DMI_WAIT_RSP
  } dmi_state_e;

  typedef struct packed {
    logic [13:0] zero;
    logic        dmihardreset;
    logic        dmireset;
    logic        rsvd;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  localparam logic [1:0] STATUS_OK   = 2'd0;
  localparam logic [1:0] STATUS_FAIL = 2'd2;
  localparam logic [1:0] STATUS_BUSY = 2'd3;

  // Unlisted instruction codes all select BYPASS.
  function automatic ir_e decode_ir(input logic [4:0] ir);
    case (ir)
      5'h01:   return IR_IDCODE;
      5'h10:   return IR_DTMCS;
      5'h11:   return IR_DMI;
      default: return IR_BYPASS;
    endcase
  endfunction

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: return tms ? TAP_SEL_DR : TAP_RTI;
      default:    return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_dmi_bridge_if.sv
// rtl/jtag_dmi_bridge_if.sv - JTAG pin and DMI request/response bundle
// master = bridge side, slave = pads / debug module side.
interface jtag_dmi_bridge_if #(
  parameter int AbitsW = 7
);
  logic              jtag_tck_i;
  logic              jtag_tms_i;
  logic              jtag_tdi_i;
  logic              jtag_trst_ni;
  logic              jtag_tdo_o;
  logic              dmi_req_valid_o;
  logic              dmi_req_ready_i;
  logic [AbitsW-1:0] dmi_req_addr_o;
  logic [1:0]        dmi_req_op_o;
  logic [31:0]       dmi_req_data_o;
  logic              dmi_rsp_valid_i;
  logic              dmi_rsp_ready_o;
  logic [31:0]       dmi_rsp_data_i;
  logic [1:0]        dmi_rsp_resp_i;
  logic              dmi_rst_no;

  modport master (
    input  jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
    output jtag_tdo_o,
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    input  dmi_req_ready_i,
    input  dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i,
    output dmi_rsp_ready_o,
    output dmi_rst_no
  );

  modport slave (
    output jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
    input  jtag_tdo_o,
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
    output dmi_req_ready_i,
    output dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i,
    input  dmi_rsp_ready_o,
    input  dmi_rst_no
  );
endinterface

// File: rtl/jtag_sync_edge.sv
// rtl/jtag_sync_edge.sv - synchronizer for the JTAG pins plus tck edge pulses
// Expects SyncStages >= 2.
module jtag_sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic clock,
  input  logic reset_i,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  input  logic i_trst_n,
  output logic o_tck_rise,
  output logic o_tck_fall,
  output logic o_tms,
  output logic o_tdi,
  output logic o_trst_n
);

  logic [SyncStages-1:0] r_tck_sync;
  logic [SyncStages-1:0] r_tms_sync;
  logic [SyncStages-1:0] r_tdi_sync;
  logic [SyncStages-1:0] r_trst_sync;
  logic                  r_tck_prev;
  logic                  w_tck;

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      r_tck_sync  <= '0;
      r_tms_sync  <= '0;
      r_tdi_sync  <= '0;
      r_trst_sync <= '0;
      r_tck_prev  <= 1'b0;
    end else begin
      r_tck_sync  <= {r_tck_sync[SyncStages-2:0], i_tck};
      r_tms_sync  <= {r_tms_sync[SyncStages-2:0], i_tms};
      r_tdi_sync  <= {r_tdi_sync[SyncStages-2:0], i_tdi};
      r_trst_sync <= {r_trst_sync[SyncStages-2:0], i_trst_n};
      r_tck_prev  <= w_tck;
    end
  end

  assign w_tck      = r_tck_sync[SyncStages-1];
  assign o_tck_rise = w_tck & ~r_tck_prev;
  assign o_tck_fall = ~w_tck & r_tck_prev;
  assign o_tms      = r_tms_sync[SyncStages-1];
  assign o_tdi      = r_tdi_sync[SyncStages-1];
  assign o_trst_n   = r_trst_sync[SyncStages-1];

endmodule

// File: rtl/jtag_dmi_bridge.sv
// rtl/jtag_dmi_bridge.sv - system-clock JTAG DTM turning DMI scans into DMI requests
// Oversampled TAP, IR/DR shift logic, DTMCS/DMI registers and the DMI handshake FSM.
module jtag_dmi_bridge
  import jtag_dtm_pkg::*;
#(
  parameter logic [31:0] IdCode     = 32'h04F5_484D,
  parameter int          AbitsW     = 7,
  parameter int          SyncStages = 2
) (
  input  logic              clock,
  input  logic              reset_i,
  jtag_dmi_bridge_if.master bus
);

  localparam int DrW = AbitsW + 34;

  logic              w_tck_rise, w_tck_fall, w_tms, w_tdi, w_trst_n;
  tap_state_e        r_tap, w_tap_next;
  dmi_state_e        r_dmi_state, w_dmi_state_next;
  logic [4:0]        r_ir, r_ir_sr;
  logic [DrW-1:0]    r_dr, w_cap_val;
  logic              r_tdo, r_dmi_rst_n;
  logic [1:0]        r_sticky, w_sticky_next, w_sticky_eff, w_status;
  logic [AbitsW-1:0] r_req_addr;
  logic [31:0]       r_req_data, r_rsp_data, w_rsp_data_eff;
  logic [1:0]        r_req_op, w_dmi_op;
  ir_e               w_ir;
  dtmcs_t            w_dtmcs;
  int unsigned       w_dr_len;
  logic              w_adv, w_cap_dr, w_shift_dr, w_upd_dr, w_cap_ir, w_shift_ir, w_upd_ir;
  logic              w_rsp_fire, w_busy, w_dmi_cap, w_dmi_upd, w_dmi_start;
  logic              w_hardreset, w_dmireset;

  function automatic logic [DrW-1:0] shift_in(input logic [DrW-1:0] dr, input logic tdi,
                                              input int unsigned len);
    return (dr >> 1) | ({{(DrW-1){1'b0}}, tdi} << (len - 1));
  endfunction

  jtag_sync_edge #(.SyncStages(SyncStages)) u_sync (
    .clock      (clock),
    .reset_i    (reset_i),
    .i_tck      (bus.jtag_tck_i),
    .i_tms      (bus.jtag_tms_i),
    .i_tdi      (bus.jtag_tdi_i),
    .i_trst_n   (bus.jtag_trst_ni),
    .o_tck_rise (w_tck_rise),
    .o_tck_fall (w_tck_fall),
    .o_tms      (w_tms),
    .o_tdi      (w_tdi),
    .o_trst_n   (w_trst_n)
  );

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) r_tap <= TAP_TLR;
    else         r_tap <= w_tap_next;
  end

  always_comb begin
    w_tap_next = r_tap;
    if (!w_trst_n)       w_tap_next = TAP_TLR;
    else if (w_tck_rise) w_tap_next = tap_next(r_tap, w_tms);
  end

  assign w_adv      = w_trst_n & w_tck_rise;
  assign w_cap_dr   = w_adv && (r_tap == TAP_CAP_DR);
  assign w_shift_dr = w_adv && (r_tap == TAP_SH_DR);
  assign w_upd_dr   = w_adv && (w_tap_next == TAP_UPD_DR);
  assign w_cap_ir   = w_adv && (r_tap == TAP_CAP_IR);
  assign w_shift_ir = w_adv && (r_tap == TAP_SH_IR);
  assign w_upd_ir   = w_adv && (w_tap_next == TAP_UPD_IR);
  assign w_ir       = decode_ir(r_ir);

  // A response landing in the same clock as a capture is already visible to that capture.
  assign w_rsp_fire     = (r_dmi_state == DMI_WAIT_RSP) && bus.dmi_rsp_valid_i;
  assign w_busy         = (r_dmi_state != DMI_IDLE) && !w_rsp_fire;
  assign w_sticky_eff   = (r_sticky == STATUS_OK && w_rsp_fire && bus.dmi_rsp_resp_i != 2'd0)
                          ? STATUS_FAIL : r_sticky;
  assign w_rsp_data_eff = w_rsp_fire ? bus.dmi_rsp_data_i : r_rsp_data;
  assign w_status       = w_busy ? STATUS_BUSY : w_sticky_eff;

  assign w_dmi_op    = r_dr[1:0];
  assign w_dmi_cap   = w_cap_dr && (w_ir == IR_DMI);
  assign w_dmi_upd   = w_upd_dr && (w_ir == IR_DMI);
  assign w_dmi_start = w_dmi_upd && !w_busy && (w_sticky_eff == STATUS_OK) &&
                       (w_dmi_op == OP_READ || w_dmi_op == OP_WRITE);
  assign w_hardreset = w_upd_dr && (w_ir == IR_DTMCS) && r_dr[17];
  assign w_dmireset  = w_upd_dr && (w_ir == IR_DTMCS) && r_dr[16];

  always_comb begin
    w_dtmcs         = '0;
    w_dtmcs.idle    = 3'd1;
    w_dtmcs.dmistat = w_sticky_eff;
    w_dtmcs.abits   = 6'(AbitsW);
    w_dtmcs.version = 4'd1;
  end

  always_comb begin
    w_cap_val = '0;
    w_dr_len  = 1;
    case (w_ir)
      IR_IDCODE: begin w_cap_val = DrW'(IdCode);  w_dr_len = 32; end
      IR_DTMCS:  begin w_cap_val = DrW'(w_dtmcs); w_dr_len = 32; end
      IR_DMI:    begin w_cap_val = {r_req_addr, w_rsp_data_eff, w_status}; w_dr_len = DrW; end
      default:   begin w_cap_val = '0; w_dr_len = 1; end
    endcase
  end

  always_comb begin
    w_sticky_next = w_sticky_eff;
    if ((w_dmi_cap || w_dmi_upd) && w_busy && w_sticky_eff == STATUS_OK)
      w_sticky_next = STATUS_BUSY;
    if (w_hardreset || w_dmireset)
      w_sticky_next = STATUS_OK;
  end

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) r_dmi_state <= DMI_IDLE;
    else         r_dmi_state <= w_dmi_state_next;
  end

  always_comb begin
    w_dmi_state_next = r_dmi_state;
    case (r_dmi_state)
      DMI_IDLE:     if (w_dmi_start)         w_dmi_state_next = DMI_REQ;
      DMI_REQ:      if (bus.dmi_req_ready_i) w_dmi_state_next = DMI_WAIT_RSP;
      DMI_WAIT_RSP: if (bus.dmi_rsp_valid_i) w_dmi_state_next = DMI_IDLE;
      default:                               w_dmi_state_next = DMI_IDLE;
    endcase
    if (w_hardreset) w_dmi_state_next = DMI_IDLE;
  end

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      r_ir        <= IR_IDCODE;
      r_ir_sr     <= '0;
      r_dr        <= '0;
      r_tdo       <= 1'b0;
      r_sticky    <= STATUS_OK;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= '0;
      r_rsp_data  <= '0;
      r_dmi_rst_n <= 1'b1;
    end else begin
      if (w_tap_next == TAP_TLR) r_ir <= IR_IDCODE;
      else if (w_upd_ir)         r_ir <= r_ir_sr;
      if (w_cap_ir)        r_ir_sr <= 5'b00001;
      else if (w_shift_ir) r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
      if (w_cap_dr)        r_dr <= w_cap_val;
      else if (w_shift_dr) r_dr <= shift_in(r_dr, w_tdi, w_dr_len);
      // TDO changes on the falling tck edge so the probe samples it stable at the next rise.
      if (r_tap == TAP_SH_DR) begin
        if (w_tck_fall) r_tdo <= r_dr[0];
      end else if (r_tap == TAP_SH_IR) begin
        if (w_tck_fall) r_tdo <= r_ir_sr[0];
      end else begin
        r_tdo <= 1'b0;
      end
      r_sticky <= w_sticky_next;
      if (w_dmi_start) begin
        r_req_addr <= r_dr[DrW-1:34];
        r_req_data <= r_dr[33:2];
        r_req_op   <= w_dmi_op;
      end
      if (w_rsp_fire) r_rsp_data <= bus.dmi_rsp_data_i;
      r_dmi_rst_n <= ~w_hardreset;
    end
  end

  assign bus.jtag_tdo_o      = r_tdo;
  assign bus.dmi_req_valid_o = (r_dmi_state == DMI_REQ);
  assign bus.dmi_rsp_ready_o = (r_dmi_state == DMI_WAIT_RSP);
  assign bus.dmi_req_addr_o  = r_req_addr;
  assign bus.dmi_req_data_o  = r_req_data;
  assign bus.dmi_req_op_o    = r_req_op;
  assign bus.dmi_rst_no      = r_dmi_rst_n;

endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// tb/tb_jtag_dmi_bridge.sv - scoreboard bench for jtag_dmi_bridge
module tb_jtag_dmi_bridge;

  localparam int AbitsW = 7;
  localparam int DrW    = AbitsW + 34;
  localparam int Half   = 6;
  localparam logic [31:0] IdCode = 32'h04F5_484D;

  logic clock   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock = ~clock;

  jtag_dmi_bridge_if #(.AbitsW(AbitsW)) bus ();

  jtag_dmi_bridge #(.IdCode(IdCode), .AbitsW(AbitsW), .SyncStages(2)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int rst_low_cnt = 0;
  int ready_delay = 3;
  int rsp_delay = 2;
  logic [31:0] rsp_data_v = '0;
  logic [1:0]  rsp_resp_v = '0;

  logic [DrW-1:0] exp_scan_q[$];
  string          exp_name_q[$];
  logic [DrW-1:0] exp_req_q[$];
  logic [DrW-1:0] scan_got;
  event           scan_ev;

  task automatic chk(input string name, input logic [DrW-1:0] act, input logic [DrW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tck_bit(input logic tms, input logic tdi, output logic tdo);
    bus.jtag_tms_i = tms;
    bus.jtag_tdi_i = tdi;
    repeat (Half) @(negedge clock);
    tdo = bus.jtag_tdo_o;
    bus.jtag_tck_i = 1'b1;
    repeat (Half) @(negedge clock);
    bus.jtag_tck_i = 1'b0;
  endtask

  task automatic tms_seq(input logic tms);
    logic t;
    tck_bit(tms, 1'b0, t);
  endtask

  // All scans start and end in Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [DrW-1:0] din, input logic [DrW-1:0] exp,
                         input string name);
    logic [DrW-1:0] got;
    logic t;
    got = '0;
    exp_scan_q.push_back(exp);
    exp_name_q.push_back(name);
    tms_seq(1); tms_seq(0); tms_seq(0);
    for (int i = 0; i < n; i++) begin
      tck_bit(i == n - 1, din[i], t);
      got[i] = t;
    end
    tms_seq(1); tms_seq(0);
    scan_got = got;
    ->scan_ev;
  endtask

  task automatic scan_ir(input logic [4:0] ir, input string name);
    logic [DrW-1:0] got;
    logic t;
    got = '0;
    exp_scan_q.push_back(DrW'(1));
    exp_name_q.push_back(name);
    tms_seq(1); tms_seq(1); tms_seq(0); tms_seq(0);
    for (int i = 0; i < 5; i++) begin
      tck_bit(i == 4, ir[i], t);
      got[i] = t;
    end
    tms_seq(1); tms_seq(0);
    scan_got = got;
    ->scan_ev;
  endtask

  task automatic enter_shift_dr(input int nbits);
    tms_seq(1); tms_seq(0); tms_seq(0);
    for (int i = 0; i < nbits; i++) tms_seq(0);
    repeat (Half) @(negedge clock);
  endtask

  initial begin
    forever begin
      @(scan_ev);
      if (exp_scan_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scan_unexpected actual=%h required=none", scan_got);
      end else begin
        chk(exp_name_q.pop_front(), scan_got, exp_scan_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (bus.dmi_req_valid_o && bus.dmi_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dmi_req_unexpected actual=%h required=none",
                   {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o});
        end else begin
          chk("dmi_req", {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o},
              exp_req_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_i && bus.dmi_rst_no === 1'b0) rst_low_cnt++;
    end
  end

  // Debug-module model: stalls ready, then answers after rsp_delay clocks.
  initial begin
    int held;
    bus.dmi_req_ready_i = 1'b0;
    bus.dmi_rsp_valid_i = 1'b0;
    bus.dmi_rsp_data_i  = '0;
    bus.dmi_rsp_resp_i  = '0;
    forever begin
      @(posedge clock); #2;
      if (bus.dmi_req_valid_o && !bus.dmi_req_ready_i) begin
        held = 0;
        repeat (ready_delay) begin
          @(posedge clock); #2;
          if (bus.dmi_req_valid_o) held++;
        end
        chk("req_valid_held", DrW'(held), DrW'(ready_delay));
        bus.dmi_req_ready_i = 1'b1;
        @(posedge clock); #2;
        bus.dmi_req_ready_i = 1'b0;
        repeat (rsp_delay) @(posedge clock);
        #2;
        chk("rsp_ready", DrW'(bus.dmi_rsp_ready_o), DrW'(1));
        bus.dmi_rsp_valid_i = 1'b1;
        bus.dmi_rsp_data_i  = rsp_data_v;
        bus.dmi_rsp_resp_i  = rsp_resp_v;
        @(posedge clock); #2;
        bus.dmi_rsp_valid_i = 1'b0;
      end
    end
  end

  initial begin
    bus.jtag_tck_i   = 1'b0;
    bus.jtag_tms_i   = 1'b0;
    bus.jtag_tdi_i   = 1'b0;
    bus.jtag_trst_ni = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_tdo", DrW'(bus.jtag_tdo_o), DrW'(0));
    chk("rst_req_valid", DrW'(bus.dmi_req_valid_o), DrW'(0));
    chk("rst_rsp_ready", DrW'(bus.dmi_rsp_ready_o), DrW'(0));
    chk("rst_dmi_rst_no", DrW'(bus.dmi_rst_no), DrW'(1));
    chk("rst_req_fields", {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o}, '0);
    reset_i = 1'b0;
    repeat (5) @(negedge clock);
    repeat (5) tms_seq(1);
    tms_seq(0);

    scan_dr(32, '0, DrW'(IdCode), "idcode");
    scan_ir(5'h10, "ir_cap_dtmcs");
    scan_dr(32, '0, DrW'(32'h1071), "dtmcs_reset");

    scan_ir(5'h11, "ir_cap_dmi");
    rsp_delay = 2; rsp_data_v = '0; rsp_resp_v = 2'd0;
    exp_req_q.push_back({7'h10, 32'h1, 2'd2});
    scan_dr(DrW, {7'h10, 32'h1, 2'd2}, '0, "dmi_first_capture");
    scan_dr(DrW, '0, {7'h10, 32'h0, 2'd0}, "dmi_write_status");

    rsp_delay = 200; rsp_data_v = 32'hDEAD_BEEF;
    exp_req_q.push_back({7'h11, 32'h0, 2'd1});
    scan_dr(DrW, {7'h11, 32'h0, 2'd1}, {7'h10, 32'h0, 2'd0}, "dmi_read_issue");
    scan_dr(DrW, {7'h12, 32'h0, 2'd1}, {7'h11, 32'h0, 2'd3}, "dmi_busy_status");
    scan_ir(5'h10, "ir_cap_dtmcs2");
    scan_dr(32, DrW'(32'h0001_0000), DrW'(32'h1C71), "dtmcs_sticky_busy");
    scan_dr(32, '0, DrW'(32'h1071), "dtmcs_after_dmireset");
    scan_ir(5'h11, "ir_cap_dmi2");
    scan_dr(DrW, '0, {7'h11, 32'hDEAD_BEEF, 2'd0}, "dmi_read_data");

    rsp_delay = 2; rsp_data_v = 32'h1234_5678; rsp_resp_v = 2'd2;
    exp_req_q.push_back({7'h20, 32'h0, 2'd1});
    scan_dr(DrW, {7'h20, 32'h0, 2'd1}, {7'h11, 32'hDEAD_BEEF, 2'd0}, "dmi_read2_issue");
    scan_dr(DrW, {7'h21, 32'h0, 2'd1}, {7'h20, 32'h1234_5678, 2'd2}, "dmi_fail_status");
    scan_dr(DrW, '0, {7'h20, 32'h1234_5678, 2'd2}, "dmi_blocked_status");
    rsp_resp_v = 2'd0; rsp_data_v = '0;
    scan_ir(5'h10, "ir_cap_dtmcs3");
    rst_low_cnt = 0;
    scan_dr(32, DrW'(32'h0002_0000), DrW'(32'h1871), "dtmcs_sticky_fail");
    chk("dmi_rst_no_pulse", DrW'(rst_low_cnt), DrW'(1));
    chk("hardreset_req_valid", DrW'(bus.dmi_req_valid_o), DrW'(0));
    scan_dr(32, '0, DrW'(32'h1071), "dtmcs_after_hardreset");
    scan_ir(5'h11, "ir_cap_dmi3");
    exp_req_q.push_back({7'h05, 32'hA5A5_0F0F, 2'd2});
    scan_dr(DrW, {7'h05, 32'hA5A5_0F0F, 2'd2}, {7'h20, 32'h1234_5678, 2'd0}, "dmi_post_hardreset");
    scan_dr(DrW, '0, {7'h05, 32'h0, 2'd0}, "dmi_write2_status");

    scan_ir(5'h10, "ir_cap_dtmcs4");
    enter_shift_dr(4);
    chk("mid_shift_tdo", DrW'(bus.jtag_tdo_o), DrW'(1));
    bus.jtag_trst_ni = 1'b0;
    repeat (8) @(negedge clock);
    chk("trst_tdo", DrW'(bus.jtag_tdo_o), DrW'(0));
    chk("trst_req_valid", DrW'(bus.dmi_req_valid_o), DrW'(0));
    bus.jtag_trst_ni = 1'b1;
    repeat (4) @(negedge clock);
    tms_seq(0);
    scan_dr(32, '0, DrW'(IdCode), "idcode_after_trst");

    scan_ir(5'h11, "ir_cap_dmi4");
    enter_shift_dr(4);
    reset_i = 1'b1;
    repeat (4) @(negedge clock);
    chk("reset_tdo", DrW'(bus.jtag_tdo_o), DrW'(0));
    chk("reset_req_valid", DrW'(bus.dmi_req_valid_o), DrW'(0));
    chk("reset_dmi_rst_no", DrW'(bus.dmi_rst_no), DrW'(1));
    reset_i = 1'b0;
    repeat (4) @(negedge clock);
    tms_seq(0);
    scan_dr(32, '0, DrW'(IdCode), "idcode_after_reset");

    repeat (50) @(negedge clock);
    chk("scan_queue_drained", DrW'(exp_scan_q.size()), '0);
    chk("req_queue_drained", DrW'(exp_req_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
